// File: rtl/lv_hv_rd_scheduler_pkg.sv
// Shared constants for the LV-side HV register poll scheduler: FSM state
// encodings, the fixed HV poll address list and default timing values.
package lv_hv_rd_scheduler_pkg;

    // Default timing: idle cycles between reads and response window.
    localparam int POLL_GAP_CYC_DEF    = 64;
    localparam int RSP_TIMEOUT_CYC_DEF = 512;

    // HV status, BIST and ADC registers, polled round-robin in this order.
    localparam int HV_POLL_ADDR_NUM = 7;
    localparam int HV_POLL_IDX_W    = $clog2(HV_POLL_ADDR_NUM);

    localparam logic [HV_POLL_IDX_W-1:0] HV_POLL_IDX_LAST =
        HV_POLL_IDX_W'(HV_POLL_ADDR_NUM - 1);

    localparam logic [7:0] HV_POLL_ADDR [HV_POLL_ADDR_NUM] = '{
        8'h08, 8'h0A, 8'h0C, 8'h0D, 8'h14, 8'h15, 8'h1F
    };

    // Read-scheduler FSM encoding.
    localparam int RD_STATE_W = 3;

    localparam logic [RD_STATE_W-1:0] RD_IDLE     = 3'd0;
    localparam logic [RD_STATE_W-1:0] RD_GAP      = 3'd1;
    localparam logic [RD_STATE_W-1:0] RD_SEND     = 3'd2;
    localparam logic [RD_STATE_W-1:0] RD_WAIT_RSP = 3'd3;
    localparam logic [RD_STATE_W-1:0] RD_NEXT     = 3'd4;

    // Advance the poll index, wrapping after the last list entry.
    function automatic logic [HV_POLL_IDX_W-1:0] next_poll_idx(
        input logic [HV_POLL_IDX_W-1:0] idx
    );
        return (idx == HV_POLL_IDX_LAST) ? '0 : idx + HV_POLL_IDX_W'(1);
    endfunction

endpackage

// File: rtl/lv_hv_rd_scheduler.sv
// LV-side OWT read scheduler. Polls the HV register list round-robin,
// separated by an idle gap, retries failed reads a bounded number of times
// and reports skipped addresses to the LV fault logic.
module lv_hv_rd_scheduler
    import lv_hv_rd_scheduler_pkg::*;
#(
    parameter int OWT_CMD_BIT_NUM = 8,
    parameter int POLL_GAP_CYC    = POLL_GAP_CYC_DEF,
    parameter int RSP_TIMEOUT_CYC = RSP_TIMEOUT_CYC_DEF,
    parameter int MAX_RETRY       = 2,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_poll_en,
    input  logic                       i_err_clr,
    output logic                       o_owt_tx_req,
    output logic [OWT_CMD_BIT_NUM-1:0] o_owt_tx_cmd,
    input  logic                       i_owt_tx_ack,
    input  logic                       i_owt_rx_ack,
    input  logic [OWT_CMD_BIT_NUM-1:0] i_owt_rx_cmd,
    input  logic                       i_owt_rx_status,
    output logic                       o_busy,
    output logic                       o_round_done,
    output logic [ERR_CNT_W-1:0]       o_err_cnt,
    output logic                       o_comm_err
);

    localparam int ADDR_W = OWT_CMD_BIT_NUM - 1;

    // Gap and response timeout never overlap, so one down-counter serves both.
    localparam int CNT_MAX = (POLL_GAP_CYC > RSP_TIMEOUT_CYC) ? POLL_GAP_CYC
                                                               : RSP_TIMEOUT_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(POLL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RSP_LOAD = CNT_W'(RSP_TIMEOUT_CYC - 1);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = {ERR_CNT_W{1'b1}};

    logic [RD_STATE_W-1:0]      state;
    logic [HV_POLL_IDX_W-1:0]   idx;
    logic [RETRY_W-1:0]         retry_cnt;
    logic [CNT_W-1:0]           cnt;
    logic                       rsp_fail;
    logic                       round_done;
    logic [ERR_CNT_W-1:0]       err_cnt;
    logic                       comm_err;

    logic [OWT_CMD_BIT_NUM-1:0] cur_cmd;
    logic                       rsp_ok;
    logic                       retry_exhausted;
    logic                       advance;
    logic                       skip;

    // Read command for the current list entry: read flag plus address.
    assign cur_cmd = {1'b1, ADDR_W'(HV_POLL_ADDR[idx])};

    // A frame is good only if it is error-free and echoes our own command.
    assign rsp_ok = !i_owt_rx_status && (i_owt_rx_cmd == cur_cmd);

    assign retry_exhausted = (retry_cnt == RETRY_LIMIT);
    assign advance         = (state == RD_NEXT) && (!rsp_fail || retry_exhausted);
    assign skip            = (state == RD_NEXT) && rsp_fail && retry_exhausted;

    // Scheduler FSM with list index, retry count and the shared down-counter.
    // NOTE: reset is synchronous, so it sits inside the clocked block and is
    // only seen on a rising edge; all sequential state uses non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= RD_IDLE;
            idx        <= '0;
            retry_cnt  <= '0;
            cnt        <= '0;
            rsp_fail   <= 1'b0;
            round_done <= 1'b0;
        end else begin
            round_done <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (i_poll_en) begin
                        state <= RD_GAP;
                        cnt   <= GAP_LOAD;
                    end
                end

                RD_GAP: begin
                    if (!i_poll_en) begin
                        state     <= RD_IDLE;
                        idx       <= '0;
                        retry_cnt <= '0;
                    end else if (cnt == '0) begin
                        state <= RD_SEND;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                // Request is held until accepted; polling enable is ignored here.
                RD_SEND: begin
                    if (i_owt_tx_ack) begin
                        state <= RD_WAIT_RSP;
                        cnt   <= RSP_LOAD;
                    end
                end

                // A frame in the last counter cycle still counts as a response.
                RD_WAIT_RSP: begin
                    if (i_owt_rx_ack) begin
                        state    <= RD_NEXT;
                        rsp_fail <= !rsp_ok;
                    end else if (cnt == '0) begin
                        state    <= RD_NEXT;
                        rsp_fail <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                RD_NEXT: begin
                    if (advance) begin
                        retry_cnt <= '0;
                        idx       <= next_poll_idx(idx);
                        if (idx == HV_POLL_IDX_LAST) begin
                            round_done <= 1'b1;
                        end
                    end else begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                    end

                    // NOTE: when polling stops, these later assignments to idx
                    // and retry_cnt override the ones above in the same cycle.
                    if (i_poll_en) begin
                        state <= RD_GAP;
                        cnt   <= GAP_LOAD;
                    end else begin
                        state     <= RD_IDLE;
                        idx       <= '0;
                        retry_cnt <= '0;
                    end
                end

                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

    // Link health: saturating count of skipped addresses plus sticky flag;
    // a clear pulse wins over a coincident skip.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt  <= '0;
            comm_err <= 1'b0;
        end else if (i_err_clr) begin
            err_cnt  <= '0;
            comm_err <= 1'b0;
        end else if (skip) begin
            comm_err <= 1'b1;
            if (err_cnt != ERR_CNT_SAT) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    // TX request is masked by reset so it drops in the same cycle reset rises.
    assign o_owt_tx_req = (state == RD_SEND) && !i_rst;
    assign o_owt_tx_cmd = o_owt_tx_req ? cur_cmd : '0;

    assign o_busy       = (state != RD_IDLE);
    assign o_round_done = round_done;
    assign o_err_cnt    = err_cnt;
    assign o_comm_err   = comm_err;

endmodule
